dcache_fill_fsm: RTL

Data-cache miss-fill engine sitting directly upstream of the cache controller. On a D-cache miss it latches the block address and streams eight word requests toward the controller and memory. It writes each returning word into the data array, then writes the tag once the whole line has arrived. It drives the controller's miss/filling handshake and the pipeline stall.

---
 rtl/dcache_fill_fsm_pkg.sv | 14 +
 rtl/dcache_fill_fsm_dff.sv | 18 +
 rtl/dcache_fill_fsm_fill_counter.sv | 21 ++
 rtl/dcache_fill_fsm.sv | 88 ++++++++
 4 files changed

// File: rtl/dcache_fill_fsm_pkg.sv
// Shared types and constants for the D-cache miss-fill engine.
package dcache_fill_fsm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILL = 2'b01,
        ST_DONE = 2'b10
    } fill_state_e;

    localparam int          LINE_WORDS  = 8;
    localparam logic [15:0] BLOCK_MASK  = 16'hFFF0;
    localparam int          WORD_STRIDE = 2;

endpackage

// File: rtl/dcache_fill_fsm_dff.sv
// Generic D flip-flop cell with synchronous active-high reset.
module dff #(
    parameter int          W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) q <= RST_VAL;
        else     q <= d;
    end

endmodule

// File: rtl/dcache_fill_fsm_fill_counter.sv
// Word counter for the fill engine: synchronous clear has priority over enable.
module fill_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) cnt_q <= '0;
        else if (en)    cnt_q <= cnt_q + 1'b1;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/dcache_fill_fsm.sv
// D-cache miss-fill engine: issues one line of word requests, writes returning
// words into the data array and writes the tag once the whole line has arrived.
module dcache_fill_fsm
    import dcache_fill_fsm_pkg::*;
#(
    parameter int LINE_WORDS = dcache_fill_fsm_pkg::LINE_WORDS,
    parameter int ADDR_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          miss_detected,
    input  logic [ADDR_W-1:0]             miss_address,
    input  logic [15:0]                   mem_data,
    input  logic                          mem_data_valid,
    output logic                          d_miss_detected,
    output logic                          d_filling_cache,
    output logic [ADDR_W-1:0]             d_address,
    output logic                          data_wr,
    output logic [$clog2(LINE_WORDS)-1:0] data_word,
    output logic [15:0]                   data_out,
    output logic                          tag_wr,
    output logic [ADDR_W-1:0]             tag_address,
    output logic                          stall
);

    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int CNT_W  = WORD_W + 1;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS * WORD_STRIDE - 1);

    fill_state_e       state_q, state_d;
    logic [1:0]        state_raw;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  req_cnt, rcv_cnt;
    logic [WORD_W-1:0] issue_idx;
    logic              in_fill, req_done, last_beat;

    dff #(.W(2), .RST_VAL(ST_IDLE)) u_state (
        .clk (clk), .rst (rst), .d (state_d), .q (state_raw)
    );
    dff #(.W(ADDR_W), .RST_VAL('0)) u_base (
        .clk (clk), .rst (rst), .d (base_d), .q (base_q)
    );

    assign state_q = fill_state_e'(state_raw);
    assign in_fill = (state_q == ST_FILL);

    // Both counters are held clear outside FILL, so every new miss restarts at word 0.
    fill_counter #(.W(CNT_W)) u_req_cnt (
        .clk (clk), .rst (rst), .clr (!in_fill), .en (in_fill && !req_done), .cnt (req_cnt)
    );
    fill_counter #(.W(CNT_W)) u_rcv_cnt (
        .clk (clk), .rst (rst), .clr (!in_fill), .en (in_fill && mem_data_valid), .cnt (rcv_cnt)
    );

    assign req_done  = req_cnt[CNT_W-1];
    assign last_beat = in_fill && mem_data_valid && (rcv_cnt == CNT_W'(LINE_WORDS - 1));

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        case (state_q)
            ST_IDLE: begin
                if (miss_detected) begin
                    state_d = ST_FILL;
                    base_d  = miss_address & LINE_MASK;
                end
            end
            ST_FILL: if (last_beat) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Once all requests are out, the address parks on the last word of the line.
    assign issue_idx = req_done ? WORD_W'(LINE_WORDS - 1) : req_cnt[WORD_W-1:0];
    assign d_address = base_q + ADDR_W'(issue_idx) * ADDR_W'(WORD_STRIDE);

    assign d_miss_detected = in_fill && !req_done;
    assign d_filling_cache = in_fill;
    assign data_wr         = in_fill && mem_data_valid;
    assign data_word       = rcv_cnt[WORD_W-1:0];
    assign data_out        = mem_data;
    assign tag_wr          = last_beat;
    assign tag_address     = base_q;
    assign stall           = (state_q != ST_IDLE) || miss_detected;

endmodule
